// File: rtl/alu.sv
// Two-operand ALU (AND / OR / ADD / SUB) with registered result and NZCV-style flags.
// Latency: exactly 1 cycle from InValid sampled high to OutValid high.
// Backpressure: none. A new operation is accepted every cycle; idle cycles hold the last result.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   Operand1/Operand2  operands A and B, WIDTH bits
//   ALUControl         00 AND, 01 OR, 10 ADD, 11 SUB (A-B)
//   InValid            qualifies the operands and ALUControl this cycle
//   ALUResult          registered result
//   Zero/Carry/Overflow/Negative  registered flags of the last accepted operation
//   OutValid           high in the cycle after an accepted operation
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [1:0]       ALUControl,
  input  logic             InValid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             Negative,
  output logic             OutValid
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;

  // Combinational datapath
  logic             is_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH:0]   sum_full;
  logic             add_ovf;
  logic [WIDTH-1:0] calc_res;
  logic             calc_carry;
  logic             calc_ovf;

  // Registered state
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             out_vld_q, out_vld_d;

  // SUB shares the adder: A + ~B + 1. The carry-out of that sum is the
  // not-borrow flag, i.e. 1 exactly when A >= B unsigned.
  always_comb begin
    is_sub   = (ALUControl == 2'b11);
    b_opnd   = is_sub ? ~Operand2 : Operand2;
    sum_full = {1'b0, Operand1} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
    // Overflow on the effective addition A + b_opnd: both addends share a sign
    // and the sum's sign differs. For SUB this is "A and B differ in sign and
    // the result sign differs from A", since b_opnd carries ~B's sign.
    add_ovf  = (Operand1[WIDTH-1] == b_opnd[WIDTH-1]) &&
               (sum_full[WIDTH-1] != Operand1[WIDTH-1]);
  end

  always_comb begin
    calc_res   = sum_full[WIDTH-1:0];
    calc_carry = sum_full[WIDTH];
    calc_ovf   = add_ovf;
    case (ALUControl)
      OP_AND: begin
        calc_res   = Operand1 & Operand2;
        calc_carry = 1'b0;
        calc_ovf   = 1'b0;
      end
      OP_OR: begin
        calc_res   = Operand1 | Operand2;
        calc_carry = 1'b0;
        calc_ovf   = 1'b0;
      end
      default: ;
    endcase
  end

  // Next state: capture on InValid, otherwise hold. OutValid simply follows InValid.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    out_vld_d = InValid;
    if (InValid) begin
      result_d = calc_res;
      zero_d   = (calc_res == '0);
      carry_d  = calc_carry;
      ovf_d    = calc_ovf;
      neg_d    = calc_res[WIDTH-1];
    end
  end

  // Reset wins over a simultaneous InValid; the presented operation is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign Negative  = neg_q;
  assign OutValid  = out_vld_q;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vectors plus randomized operations against a
// reference model computed with wide integer arithmetic.
module tb_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [1:0]   ALUControl;
  logic         InValid;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic         Carry;
  logic         Overflow;
  logic         Negative;
  logic         OutValid;

  alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Operand1   (Operand1),
    .Operand2   (Operand2),
    .ALUControl (ALUControl),
    .InValid    (InValid),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .Negative   (Negative),
    .OutValid   (OutValid)
  );

  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;
  int n_failed = 0;

  // Expected visible state
  logic [W-1:0] exp_res;
  logic         exp_zero, exp_carry, exp_ovf, exp_neg, exp_vld;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_passed++;
    end else begin
      n_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".res"},  ALUResult,            exp_res);
    check({tag, ".zero"}, {31'b0, Zero},     {31'b0, exp_zero});
    check({tag, ".cy"},   {31'b0, Carry},    {31'b0, exp_carry});
    check({tag, ".ov"},   {31'b0, Overflow}, {31'b0, exp_ovf});
    check({tag, ".neg"},  {31'b0, Negative}, {31'b0, exp_neg});
    check({tag, ".vld"},  {31'b0, OutValid}, {31'b0, exp_vld});
  endtask

  // Reference: evaluate with 64-bit integers straight from the arithmetic
  // definitions (unsigned sum/compare for carry, signed range for overflow).
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] ctl);
    longint ua, ub, us, sa, sb, ss;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_carry = 1'b0;
    exp_ovf   = 1'b0;
    case (ctl)
      2'b00: exp_res = a & b;
      2'b01: exp_res = a | b;
      2'b10: begin
        us = ua + ub;
        exp_res   = us[W-1:0];
        exp_carry = (us >= 64'sd4294967296);
        ss = sa + sb;
        exp_ovf   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: begin
        us = ua - ub;
        exp_res   = us[W-1:0];
        exp_carry = (ua >= ub);
        ss = sa - sb;
        exp_ovf   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
    endcase
    exp_zero = (exp_res == 0);
    exp_neg  = exp_res[W-1];
  endtask

  // Present one cycle of inputs, advance a clock, update the model, check.
  task automatic step(input logic rst, input logic vld, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [1:0] ctl, input string tag);
    reset      = rst;
    InValid    = vld;
    Operand1   = a;
    Operand2   = b;
    ALUControl = ctl;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_res = '0; exp_zero = 1'b1; exp_carry = 1'b0; exp_ovf = 1'b0; exp_neg = 1'b0;
      exp_vld = 1'b0;
    end else begin
      if (vld) model(a, b, ctl);
      exp_vld = vld;
    end
    check_all(tag);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] edges [4];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  initial begin
    reset = 1'b1; InValid = 1'b0; Operand1 = '0; Operand2 = '0; ALUControl = 2'b00;

    step(1'b1, 1'b0, 32'h0, 32'h0, 2'b00, "reset");

    // Directed vectors with hand-computed constants alongside the model
    step(1'b0, 1'b1, 32'h0000_0055, 32'h0000_40AA, 2'b00, "and");
    check("and.const", ALUResult, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h0000_0055, 32'h0000_40AA, 2'b01, "or");
    check("or.const", ALUResult, 32'h0000_40FF);
    step(1'b0, 1'b1, 32'h0000_0055, 32'h0000_40AA, 2'b10, "add");
    check("add.const", ALUResult, 32'h0000_40FF);
    step(1'b0, 1'b1, 32'h0000_0055, 32'h0000_40AA, 2'b11, "sub");
    check("sub.const", ALUResult, 32'hFFFF_BFAB);
    check("sub.neg_const", {31'b0, Negative}, 32'h1);
    step(1'b0, 1'b1, 32'h0000_0055, 32'h0000_0055, 2'b11, "sub_eq");
    check("sub_eq.cy_const", {31'b0, Carry}, 32'h1);
    step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 2'b10, "add_ovf");
    check("add_ovf.const", {31'b0, Overflow}, 32'h1);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b10, "add_wrap");
    check("add_wrap.cy_const", {31'b0, Carry}, 32'h1);
    step(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 2'b11, "sub_ovf");
    check("sub_ovf.const", ALUResult, 32'h7FFF_FFFF);

    // Idle cycles: outputs hold, OutValid drops; operands toggling must not leak
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom(), $urandom(), 2'b10, "hold");
    check("hold.const", ALUResult, 32'h7FFF_FFFF);

    // Reset together with InValid discards the operation
    step(1'b1, 1'b1, 32'h1234_5678, 32'h1, 2'b10, "rst_vld");
    check("rst_vld.zero_const", {31'b0, Zero}, 32'h1);

    // Mid-stream reset, then the first operation after reset appears one cycle later
    step(1'b0, 1'b1, 32'h0000_0003, 32'h0000_0004, 2'b10, "pre_rst");
    step(1'b1, 1'b1, 32'h0000_0009, 32'h0000_0001, 2'b11, "mid_rst");
    step(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0020, 2'b01, "post_rst");
    check("post_rst.const", ALUResult, 32'h0000_0030);

    // Randomized traffic including back-to-back valids, idles and rare resets
    for (int i = 0; i < 400; i++) begin
      logic r, v;
      r = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, v, pick_operand(), pick_operand(), 2'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
